win3x3_gen: RTL and testbench

- Downstream consumer of the line-buffer read controller.
- Takes the three line-RAM read data words and the registered row-select codes, and routes them into top, middle and bottom row order.
- Assembles a 3x3 pixel window using per-row shift registers and presents one window per accepted pixel column, starting at the third column.
- Feeds the edge-detection kernel, and forwards row-end and frame-end markers aligned with the window pipeline.

---
 rtl/win3x3_gen_pkg.sv | 31 +++
 rtl/win3x3_gen_row_mux.sv | 30 +++
 rtl/win3x3_gen.sv | 139 +++++++++++++
 tb/tb_win3x3_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/win3x3_gen_pkg.sv
// Shared constants for the 3x3 window generator: row-select codes, window packing, column states.
package win3x3_gen_pkg;

  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_B    = 2'd2;
  localparam logic [1:0] SEL_C    = 2'd3;

  localparam int unsigned WIN_N = 9;
  localparam int unsigned P00 = 0;
  localparam int unsigned P01 = 1;
  localparam int unsigned P02 = 2;
  localparam int unsigned P10 = 3;
  localparam int unsigned P11 = 4;
  localparam int unsigned P12 = 5;
  localparam int unsigned P20 = 6;
  localparam int unsigned P21 = 7;
  localparam int unsigned P22 = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } col_state_e;

  // Bit offset of window element idx; p00 sits at the MSB end.
  function automatic int unsigned win_lsb(input int unsigned idx, input int unsigned dw);
    return (WIN_N - 1 - idx) * dw;
  endfunction

endpackage

// File: rtl/win3x3_gen_row_mux.sv
// Registered 4:1 row select; code 0 injects a zero border pixel.
module win_row_mux
  import win3x3_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              en,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      q <= '0;
    end else if (en) begin
      case (sel)
        SEL_ZERO: q <= '0;
        SEL_A:    q <= a;
        SEL_B:    q <= b;
        SEL_C:    q <= c;
      endcase
    end
  end

endmodule

// File: rtl/win3x3_gen.sv
// 3x3 window assembler: aligns line-RAM reads, routes rows, shifts columns and
// emits one window per accepted pixel from the third column of each row onward.
module win3x3_gen
  import win3x3_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned COL_W  = 11
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  rama_rden,
  input  logic                  ramb_rden,
  input  logic                  ramc_rden,
  input  logic [DATA_W-1:0]     rama_q,
  input  logic [DATA_W-1:0]     ramb_q,
  input  logic [DATA_W-1:0]     ramc_q,
  input  logic [1:0]            sel_row1,
  input  logic [1:0]            sel_row2,
  input  logic [1:0]            sel_row3,
  input  logic                  row_end_rd,
  input  logic                  frame_end_rd,
  output logic [9*DATA_W-1:0]   win,
  output logic                  win_valid,
  output logic                  win_row_end,
  output logic                  win_frame_end
);

  logic rden_any;
  logic pix_v, re_d, fe_d;

  assign rden_any = rama_rden | ramb_rden | ramc_rden;

  // S0: match control timing to the RAM read latency.
  if (RD_LAT == 0) begin : g_nodly
    assign pix_v = rden_any;
    assign re_d  = row_end_rd;
    assign fe_d  = frame_end_rd;
  end else begin : g_dly
    logic [RD_LAT-1:0] v_sr, re_sr, fe_sr;
    always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
        v_sr  <= '0;
        re_sr <= '0;
        fe_sr <= '0;
      end else begin
        v_sr[0]  <= rden_any;
        re_sr[0] <= row_end_rd;
        fe_sr[0] <= frame_end_rd;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
          v_sr[i]  <= v_sr[i-1];
          re_sr[i] <= re_sr[i-1];
          fe_sr[i] <= fe_sr[i-1];
        end
      end
    end
    assign pix_v = v_sr[RD_LAT-1];
    assign re_d  = re_sr[RD_LAT-1];
    assign fe_d  = fe_sr[RD_LAT-1];
  end

  logic [DATA_W-1:0] row_px [3];
  logic [1:0]        row_sel [3];

  assign row_sel[0] = sel_row1;
  assign row_sel[1] = sel_row2;
  assign row_sel[2] = sel_row3;

  for (genvar r = 0; r < 3; r++) begin : g_row
    win_row_mux #(.DATA_W(DATA_W)) u_mux (
      .clk  (clk),
      .aclr (aclr),
      .en   (pix_v),
      .sel  (row_sel[r]),
      .a    (rama_q),
      .b    (ramb_q),
      .c    (ramc_q),
      .q    (row_px[r])
    );
  end

  logic             s1_v, s1_re, s1_fe;
  logic [COL_W-1:0] cnt;
  logic [DATA_W-1:0] px [3][3];
  col_state_e       col_st;

  always_comb begin
    col_st = RUN;
    if (cnt == '0)               col_st = IDLE;
    else if (cnt == COL_W'(1))   col_st = FILL;
  end

  // S1 control pipe, S2 column shift, counter and markers.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      s1_v          <= 1'b0;
      s1_re         <= 1'b0;
      s1_fe         <= 1'b0;
      cnt           <= '0;
      win_valid     <= 1'b0;
      win_row_end   <= 1'b0;
      win_frame_end <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) px[r][c] <= '0;
      end
    end else begin
      s1_v          <= pix_v;
      s1_re         <= re_d;
      s1_fe         <= fe_d;
      win_valid     <= s1_v && (col_st == RUN);
      win_row_end   <= s1_re;
      win_frame_end <= s1_fe;
      if (s1_v) begin
        for (int r = 0; r < 3; r++) begin
          px[r][0] <= px[r][1];
          px[r][1] <= px[r][2];
          px[r][2] <= row_px[r];
        end
        if (cnt != {COL_W{1'b1}}) cnt <= cnt + COL_W'(1);
      end
      // A marker ends the row after the coincident pixel has been counted.
      if (s1_re || s1_fe) cnt <= '0;
    end
  end

  always_comb begin
    win = '0;
    win[win_lsb(P00, DATA_W) +: DATA_W] = px[0][0];
    win[win_lsb(P01, DATA_W) +: DATA_W] = px[0][1];
    win[win_lsb(P02, DATA_W) +: DATA_W] = px[0][2];
    win[win_lsb(P10, DATA_W) +: DATA_W] = px[1][0];
    win[win_lsb(P11, DATA_W) +: DATA_W] = px[1][1];
    win[win_lsb(P12, DATA_W) +: DATA_W] = px[1][2];
    win[win_lsb(P20, DATA_W) +: DATA_W] = px[2][0];
    win[win_lsb(P21, DATA_W) +: DATA_W] = px[2][1];
    win[win_lsb(P22, DATA_W) +: DATA_W] = px[2][2];
  end

endmodule

// File: tb/tb_win3x3_gen.sv
// Self-checking bench for win3x3_gen: directed rows plus random traffic against
// a column-history reference model.
module tb_win3x3_gen;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned COL_W  = 11;
  localparam int unsigned WW     = 9 * DATA_W;

  logic              clk = 1'b0;
  logic              aclr;
  logic              rama_rden, ramb_rden, ramc_rden;
  logic [DATA_W-1:0] rama_q, ramb_q, ramc_q;
  logic [1:0]        sel_row1, sel_row2, sel_row3;
  logic              row_end_rd, frame_end_rd;
  logic [WW-1:0]     win;
  logic              win_valid, win_row_end, win_frame_end;

  win3x3_gen #(.DATA_W(DATA_W), .RD_LAT(RD_LAT), .COL_W(COL_W)) dut (
    .clk           (clk),
    .aclr          (aclr),
    .rama_rden     (rama_rden),
    .ramb_rden     (ramb_rden),
    .ramc_rden     (ramc_rden),
    .rama_q        (rama_q),
    .ramb_q        (ramb_q),
    .ramc_q        (ramc_q),
    .sel_row1      (sel_row1),
    .sel_row2      (sel_row2),
    .sel_row3      (sel_row3),
    .row_end_rd    (row_end_rd),
    .frame_end_rd  (frame_end_rd),
    .win           (win),
    .win_valid     (win_valid),
    .win_row_end   (win_row_end),
    .win_frame_end (win_frame_end)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] w;
    logic          v;
    logic          re;
    logic          fe;
  } exp_t;

  exp_t              exp_q[$];
  logic [3*DATA_W-1:0] hist [3];   // last three columns pushed, oldest first; {top,mid,bot}
  int                row_cnt;
  logic              prev_v, prev_re, prev_fe;
  logic [DATA_W-1:0] pa, pb, pc;
  logic [1:0]        ps1, ps2, ps3;
  int                errors = 0;
  int                checks = 0;

  function automatic logic [DATA_W-1:0] pick(input logic [1:0] s, input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c);
    case (s)
      2'd0:    return '0;
      2'd1:    return a;
      2'd2:    return b;
      default: return c;
    endcase
  endfunction

  function automatic logic [WW-1:0] cur_win();
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(8 - (r*3 + c))*DATA_W +: DATA_W] = hist[c][(2 - r)*DATA_W +: DATA_W];
    return w;
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
    row_cnt = 0;
    prev_v = 1'b0; prev_re = 1'b0; prev_fe = 1'b0;
    pa = '0; pb = '0; pc = '0; ps1 = '0; ps2 = '0; ps3 = '0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_idle_inputs();
    rama_rden = 1'b0; ramb_rden = 1'b0; ramc_rden = 1'b0;
    row_end_rd = 1'b0; frame_end_rd = 1'b0;
    rama_q = DATA_W'($urandom); ramb_q = DATA_W'($urandom); ramc_q = DATA_W'($urandom);
    sel_row1 = 2'($urandom); sel_row2 = 2'($urandom); sel_row3 = 2'($urandom);
  endtask

  // One clock: check this cycle's outputs, issue a read request (data arrives next cycle),
  // present data for the previous request, and advance the model.
  task automatic cycle(input logic [2:0] rd, input logic re, input logic fe,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [DATA_W-1:0] c,
                       input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL exp_queue observed=empty expected=entry");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk("win", win, e.w);
    chk("win_valid", WW'(win_valid), WW'(e.v));
    chk("win_row_end", WW'(win_row_end), WW'(e.re));
    chk("win_frame_end", WW'(win_frame_end), WW'(e.fe));

    rama_rden = rd[0]; ramb_rden = rd[1]; ramc_rden = rd[2];
    row_end_rd = re; frame_end_rd = fe;
    if (prev_v) begin
      rama_q = pa; ramb_q = pb; ramc_q = pc;
      sel_row1 = ps1; sel_row2 = ps2; sel_row3 = ps3;
    end else begin
      rama_q = DATA_W'($urandom); ramb_q = DATA_W'($urandom); ramc_q = DATA_W'($urandom);
      sel_row1 = 2'($urandom); sel_row2 = 2'($urandom); sel_row3 = 2'($urandom);
    end

    e = '0;
    if (prev_v) begin
      hist[0] = hist[1];
      hist[1] = hist[2];
      hist[2] = {pick(sel_row1, rama_q, ramb_q, ramc_q),
                 pick(sel_row2, rama_q, ramb_q, ramc_q),
                 pick(sel_row3, rama_q, ramb_q, ramc_q)};
      e.v = (row_cnt >= 2);
      row_cnt++;
    end
    if (prev_re || prev_fe) row_cnt = 0;
    e.re = prev_re;
    e.fe = prev_fe;
    e.w  = cur_win();
    exp_q.push_back(e);

    prev_v = |rd; prev_re = re; prev_fe = fe;
    pa = a; pb = b; pc = c; ps1 = s1; ps2 = s2; ps3 = s3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(3'b000, 1'b0, 1'b0, DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), 2'd1, 2'd2, 2'd3);
  endtask

  // Row of n random pixels with fixed selects; markers on the last pixel.
  task automatic rand_row(input int n, input logic [2:0] rd, input logic re, input logic fe,
                          input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3);
    for (int i = 0; i < n; i++)
      cycle(rd, re && (i == n-1), fe && (i == n-1),
            DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), s1, s2, s3);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    aclr = 1'b0;
    drive_idle_inputs();
    #1;
    chk("rst_win", win, '0);
    chk("rst_win_valid", WW'(win_valid), '0);
    chk("rst_win_row_end", WW'(win_row_end), '0);
    chk("rst_win_frame_end", WW'(win_frame_end), '0);
    repeat (2) @(posedge clk);
    #1;
    aclr = 1'b1;
    model_reset();
  endtask

  initial begin
    aclr = 1'b0;
    drive_idle_inputs();
    model_reset();
    #2;
    chk("init_win", win, '0);
    chk("init_win_valid", WW'(win_valid), '0);
    @(posedge clk);
    #1;
    aclr = 1'b1;

    // Continuous row A=10.., B=20.., C=30.., then a bare row end.
    for (int i = 0; i < 6; i++)
      cycle(3'b001, 1'b0, 1'b0, DATA_W'(10+i), DATA_W'(20+i), DATA_W'(30+i), 2'd1, 2'd2, 2'd3);
    cycle(3'b000, 1'b1, 1'b0, '0, '0, '0, 2'd1, 2'd2, 2'd3);
    idle(3);

    // Alternate-cycle reads; window must hold between pulses.
    for (int i = 0; i < 6; i++) begin
      cycle(3'b001, i == 5, 1'b0, DATA_W'(10+i), DATA_W'(20+i), DATA_W'(30+i), 2'd1, 2'd2, 2'd3);
      idle(1);
    end
    idle(2);

    // Zero-padded top row, driven via RAM C enable only.
    rand_row(5, 3'b100, 1'b1, 1'b0, 2'd0, 2'd1, 2'd2);
    idle(2);

    // Row end on 5th pixel, then a back-to-back 3-pixel row.
    rand_row(5, 3'b010, 1'b1, 1'b0, 2'd1, 2'd2, 2'd3);
    rand_row(3, 3'b010, 1'b1, 1'b0, 2'd3, 2'd1, 2'd2);
    idle(3);

    // Frame end with row end, a short row, then a fresh row.
    rand_row(4, 3'b001, 1'b1, 1'b1, 2'd1, 2'd2, 2'd3);
    rand_row(2, 3'b001, 1'b1, 1'b0, 2'd1, 2'd2, 2'd3);
    rand_row(3, 3'b001, 1'b0, 1'b1, 2'd2, 2'd3, 2'd1);
    idle(3);

    // Mid-stream reset, then a row must refill from scratch.
    rand_row(4, 3'b001, 1'b0, 1'b0, 2'd1, 2'd2, 2'd3);
    do_reset();
    rand_row(4, 3'b001, 1'b1, 1'b0, 2'd1, 2'd2, 2'd3);
    idle(3);

    // Random traffic: gaps, mixed enables, random selects and markers.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      cycle(rd, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
            DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
            2'($urandom), 2'($urandom), 2'($urandom));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
